// File: rtl/alu_pipelined_stream_pkg.sv
// Shared types and defaults for the streaming pipelined ALU.
// Optional feature macro: ALU_PIPE_TAG_EN (sideband tag carried with each operation).
package alu_pipelined_pkg;

   localparam int unsigned DefaultWidth  = 32;
   localparam int unsigned DefaultStages = 2;
   localparam int unsigned DefaultTagW   = 4;

   typedef enum logic [3:0] {
      OpAdd = 4'b0000,
      OpSub = 4'b0001,
      OpAnd = 4'b0010,
      OpOr  = 4'b0011,
      OpXor = 4'b0100,
      OpSlt = 4'b0101,
      OpSll = 4'b0110,
      OpSrl = 4'b0111,
      OpSra = 4'b1000
   } alu_op_e;

   // Result record at the default width; modules with a different WIDTH mirror this layout.
   typedef struct packed {
      logic [DefaultWidth-1:0] Result;
      logic                    Z;
      logic                    N;
      logic                    C;
      logic                    OF;
   } alu_res_t;

endpackage

// File: rtl/alu_pipelined_stream_if.sv
// Operand-in / result-out handshake bundle for alu_pipelined_stream.
// Optional feature macro: ALU_PIPE_TAG_EN adds tag_i/tag_o.
interface alu_pipelined_stream_if #(
   parameter int unsigned WIDTH = alu_pipelined_pkg::DefaultWidth
`ifdef ALU_PIPE_TAG_EN
   ,
   parameter int unsigned TAG_W = alu_pipelined_pkg::DefaultTagW
`endif
) ();

   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] A_i;
   logic [WIDTH-1:0] B_i;
   logic [3:0]       ALUControl_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] Result_o;
   logic             Z_o;
   logic             N_o;
   logic             C_o;
   logic             OF_o;
`ifdef ALU_PIPE_TAG_EN
   logic [TAG_W-1:0] tag_i;
   logic [TAG_W-1:0] tag_o;

   modport slave (
      input  valid_i, A_i, B_i, ALUControl_i, tag_i, ready_i,
      output ready_o, valid_o, Result_o, Z_o, N_o, C_o, OF_o, tag_o
   );
   modport master (
      output valid_i, A_i, B_i, ALUControl_i, tag_i, ready_i,
      input  ready_o, valid_o, Result_o, Z_o, N_o, C_o, OF_o, tag_o
   );
`else
   modport slave (
      input  valid_i, A_i, B_i, ALUControl_i, ready_i,
      output ready_o, valid_o, Result_o, Z_o, N_o, C_o, OF_o
   );
   modport master (
      output valid_i, A_i, B_i, ALUControl_i, ready_i,
      input  ready_o, valid_o, Result_o, Z_o, N_o, C_o, OF_o
   );
`endif

endinterface

// File: rtl/alu_pipelined_stream_alu_core.sv
// Purely combinational ALU: operands and opcode in, result and Z/N/C/OF out.
// Undefined opcodes return zero with every flag clear.
module alu_core
   import alu_pipelined_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             z_o,
   output logic             n_o,
   output logic             c_o,
   output logic             of_o
);

   localparam int unsigned ShW = $clog2(WIDTH);

   logic             sub;
   logic             defined;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [ShW-1:0]   shamt;

   // Shared adder handles ADD and SUB (A + ~B + 1); everything else is decoded per opcode.
   always_comb begin
      sub      = (op_i == OpSub);
      b_eff    = sub ? ~b_i : b_i;
      sum      = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      shamt    = b_i[ShW-1:0];
      result_o = '0;
      c_o      = 1'b0;
      of_o     = 1'b0;
      defined  = 1'b1;
      case (alu_op_e'(op_i))
         OpAdd, OpSub: begin
            result_o = sum[WIDTH-1:0];
            c_o      = sum[WIDTH];
            of_o     = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         end
         OpAnd:   result_o = a_i & b_i;
         OpOr:    result_o = a_i | b_i;
         OpXor:   result_o = a_i ^ b_i;
         OpSlt:   result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OpSll:   result_o = a_i << shamt;
         OpSrl:   result_o = a_i >> shamt;
         OpSra:   result_o = $unsigned($signed(a_i) >>> shamt);
         default: defined  = 1'b0;
      endcase
      z_o = defined && (result_o == '0);
      n_o = defined && result_o[WIDTH-1];
   end

endmodule

// File: rtl/alu_pipelined_stream.sv
// Back-pressurable pipelined ALU: stage 1 holds operands, the ALU sits between stage 1 and 2,
// stages 2..STAGES carry result and flags. Each stage has its own valid bit so bubbles collapse.
// Optional feature macro: ALU_PIPE_TAG_EN carries a sideband tag through every stage.
module alu_pipelined_stream
   import alu_pipelined_pkg::*;
#(
   parameter int unsigned WIDTH  = DefaultWidth,
   parameter int unsigned STAGES = DefaultStages,
   parameter int unsigned TAG_W  = DefaultTagW
) (
   input logic                   clk_i,
   input logic                   rst_i,
   alu_pipelined_stream_if.slave bus
);

   // Same layout as alu_res_t, sized by WIDTH.
   typedef struct packed {
      logic [WIDTH-1:0] Result;
      logic             Z;
      logic             N;
      logic             C;
      logic             OF;
   } stage_res_t;

   if (WIDTH < 8 || STAGES < 2 || TAG_W == 0) begin : g_cfg_err
      $error("alu_pipelined_stream: unsupported WIDTH/STAGES/TAG_W");
   end

   logic [STAGES:1] vld;
   logic [STAGES:1] rdy;
   stage_res_t      res [STAGES:1];

   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [3:0]       s1_op_q;

   logic [WIDTH-1:0] alu_result;
   logic             alu_z;
   logic             alu_n;
   logic             alu_c;
   logic             alu_of;

`ifdef ALU_PIPE_TAG_EN
   logic [TAG_W-1:0] s1_tag_q;
   logic [TAG_W-1:0] tag [STAGES:1];
`endif

   // Stage k may load when some stage from k to the output is empty or the consumer takes one.
   always_comb begin
      for (int k = 1; k <= STAGES; k++) begin
         rdy[k] = bus.ready_i;
         for (int j = k; j <= STAGES; j++) begin
            if (!vld[j]) rdy[k] = 1'b1;
         end
      end
   end

   assign bus.ready_o = rdy[1] && !rst_i;

   // Stage 1: capture operands, opcode and tag on an accepted transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
`ifdef ALU_PIPE_TAG_EN
         s1_tag_q   <= '0;
`endif
      end else if (rdy[1]) begin
         s1_valid_q <= bus.valid_i;
         if (bus.valid_i) begin
            s1_a_q   <= bus.A_i;
            s1_b_q   <= bus.B_i;
            s1_op_q  <= bus.ALUControl_i;
`ifdef ALU_PIPE_TAG_EN
            s1_tag_q <= bus.tag_i;
`endif
         end
      end
   end

   assign vld[1] = s1_valid_q;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_alu_core (
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .op_i     (s1_op_q),
      .result_o (alu_result),
      .z_o      (alu_z),
      .n_o      (alu_n),
      .c_o      (alu_c),
      .of_o     (alu_of)
   );

   assign res[1] = {alu_result, alu_z, alu_n, alu_c, alu_of};
`ifdef ALU_PIPE_TAG_EN
   assign tag[1] = s1_tag_q;
`endif

   for (genvar k = 2; k <= STAGES; k++) begin : g_stage
      logic       v_q;
      stage_res_t r_q;
`ifdef ALU_PIPE_TAG_EN
      logic [TAG_W-1:0] t_q;
`endif

      // Advance with downstream room; data holds across bubbles so a stalled output stays put.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            v_q <= 1'b0;
            r_q <= '0;
`ifdef ALU_PIPE_TAG_EN
            t_q <= '0;
`endif
         end else if (rdy[k]) begin
            v_q <= vld[k-1];
            if (vld[k-1]) begin
               r_q <= res[k-1];
`ifdef ALU_PIPE_TAG_EN
               t_q <= tag[k-1];
`endif
            end
         end
      end

      assign vld[k] = v_q;
      assign res[k] = r_q;
`ifdef ALU_PIPE_TAG_EN
      assign tag[k] = t_q;
`endif
   end

   assign bus.valid_o  = vld[STAGES];
   assign bus.Result_o = res[STAGES].Result;
   assign bus.Z_o      = res[STAGES].Z;
   assign bus.N_o      = res[STAGES].N;
   assign bus.C_o      = res[STAGES].C;
   assign bus.OF_o     = res[STAGES].OF;
`ifdef ALU_PIPE_TAG_EN
   assign bus.tag_o    = tag[STAGES];
`endif

endmodule

// File: tb/tb_alu_pipelined_stream.sv
// Directed bench for alu_pipelined_stream (WIDTH=32, STAGES=3).
// Tag checks compile in when ALU_PIPE_TAG_EN is defined.
module tb_alu_pipelined_stream;

   localparam int unsigned W  = 32;
   localparam int unsigned ST = 3;
   localparam int unsigned TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   alu_pipelined_stream_if #(
      .WIDTH (W)
`ifdef ALU_PIPE_TAG_EN
      ,
      .TAG_W (TW)
`endif
   ) bus ();

   alu_pipelined_stream #(
      .WIDTH  (W),
      .STAGES (ST),
      .TAG_W  (TW)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        c;
      logic        of_f;
   } vec_t;

   typedef struct {
      int idx;
      int tag;
   } exp_t;

   vec_t tbl [16];
   exp_t expq [$];
   int   out_cyc [$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // One clock cycle, entered and left at the falling edge: drive, look at both handshakes,
   // score any delivered result against the oldest outstanding vector.
   task automatic step(input logic v, input int idx, input int tag, input logic rdy,
                       output logic acc);
      exp_t e;
      bus.valid_i      = v;
      bus.A_i          = tbl[idx].a;
      bus.B_i          = tbl[idx].b;
      bus.ALUControl_i = tbl[idx].op;
      bus.ready_i      = rdy;
`ifdef ALU_PIPE_TAG_EN
      bus.tag_i        = TW'(tag);
`endif
      #1;
      acc = v && bus.ready_o;
      if (bus.valid_o && bus.ready_i) begin
         if (expq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL spurious_output: got valid_o=1 result %h, want no output", bus.Result_o);
         end else begin
            e = expq.pop_front();
            check($sformatf("result_flags[%0d]", e.idx),
                  {28'b0, bus.Result_o, bus.Z_o, bus.N_o, bus.C_o, bus.OF_o},
                  {28'b0, tbl[e.idx].res, tbl[e.idx].z, tbl[e.idx].n, tbl[e.idx].c,
                   tbl[e.idx].of_f});
`ifdef ALU_PIPE_TAG_EN
            check($sformatf("tag[%0d]", e.idx), 64'(bus.tag_o), 64'(TW'(e.tag)));
`endif
            out_cyc.push_back(cyc);
         end
      end
      if (acc) expq.push_back('{idx, tag});
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input string name);
      logic a;
      int   guard;
      guard = 0;
      while (expq.size() > 0 && guard < 30) begin
         step(1'b0, 0, 0, 1'b1, a);
         guard++;
      end
      check(name, 64'(expq.size()), 64'd0);
   endtask

   initial begin
      logic        a;
      int          nacc;
      logic [35:0] snap;

      //        a             b             op       result        z     n     c     of
      tbl[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{32'h00000005, 32'h00000005, 4'b0001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{32'h00000003, 32'h00000005, 4'b0001, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{32'h80000000, 32'h00000021, 4'b1000, 32'hC0000000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0101, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{32'h12345678, 32'h00000001, 4'b1111, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{32'h0F0F0000, 32'h000000FF, 4'b0011, 32'h0F0F00FF, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{32'hAAAAAAAA, 32'hFFFFFFFF, 4'b0100, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{32'h00000001, 32'h0000001F, 4'b0110, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{32'h80000000, 32'h00000024, 4'b0111, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{32'h80000000, 32'h00000001, 4'b0001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{32'h00000001, 32'hFFFFFFFF, 4'b0101, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{32'h80000000, 32'h80000000, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[15] = '{32'h00000000, 32'h00000000, 4'b1001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};

      bus.valid_i      = 1'b0;
      bus.A_i          = '0;
      bus.B_i          = '0;
      bus.ALUControl_i = '0;
      bus.ready_i      = 1'b1;
`ifdef ALU_PIPE_TAG_EN
      bus.tag_i        = '0;
`endif

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("ready_o_in_reset", 64'(bus.ready_o), 64'd0);
      check("valid_o_in_reset", 64'(bus.valid_o), 64'd0);
      check("outputs_in_reset", {28'b0, bus.Result_o, bus.Z_o, bus.N_o, bus.C_o, bus.OF_o}, 64'd0);
`ifdef ALU_PIPE_TAG_EN
      check("tag_o_in_reset", 64'(bus.tag_o), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Latency: accepted at edge n, visible after edge n+2
      step(1'b1, 0, 1, 1'b1, a);
      check("lat_accept", 64'(a), 64'd1);
      check("lat_after_n", 64'(bus.valid_o), 64'd0);
      step(1'b0, 0, 0, 1'b1, a);
      check("lat_after_n1", 64'(bus.valid_o), 64'd0);
      step(1'b0, 0, 0, 1'b1, a);
      check("lat_after_n2", 64'(bus.valid_o), 64'd1);
      drain("lat_drain");

      // Back-to-back table with ready_i held high
      out_cyc.delete();
      nacc = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, i, i, 1'b1, a);
         nacc += int'(a);
      end
      check("b2b_accepted", 64'(nacc), 64'd16);
      drain("b2b_drain");
      check("b2b_out_count", 64'(out_cyc.size()), 64'd16);
      if (out_cyc.size() == 16) check("b2b_consecutive", 64'(out_cyc[15] - out_cyc[0]), 64'd15);

      // Stall: ready_i low for six cycles while offering vectors 6..11
      out_cyc.delete();
      nacc = 0;
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 6 + k, 6 + k, 1'b0, a);
         nacc += int'(a);
      end
      check("stall_accepted", 64'(nacc), 64'd3);
      check("stall_valid_o", 64'(bus.valid_o), 64'd1);
      snap = {bus.Result_o, bus.Z_o, bus.N_o, bus.C_o, bus.OF_o};
      check("stall_head", {28'b0, snap},
            {28'b0, tbl[6].res, tbl[6].z, tbl[6].n, tbl[6].c, tbl[6].of_f});
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 9, 9, 1'b0, a);
         check("stall_ready_o_low", 64'(a), 64'd0);
         check("stall_stable", {28'b0, bus.Result_o, bus.Z_o, bus.N_o, bus.C_o, bus.OF_o},
               {28'b0, snap});
      end
      // Release: the input in the same cycle as ready_i rising must be taken
      step(1'b1, 12, 12, 1'b1, a);
      check("release_same_cycle_accept", 64'(a), 64'd1);
      drain("stall_drain");
      check("stall_out_count", 64'(out_cyc.size()), 64'd4);

      // Reset mid-stream with tags in flight
      for (int k = 0; k < 6; k++) step(1'b1, 1 + k, k, 1'b1, a);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid_o", 64'(bus.valid_o), 64'd0);
      check("midrst_ready_o", 64'(bus.ready_o), 64'd0);
      check("midrst_outputs", {28'b0, bus.Result_o, bus.Z_o, bus.N_o, bus.C_o, bus.OF_o}, 64'd0);
`ifdef ALU_PIPE_TAG_EN
      check("midrst_tag_o", 64'(bus.tag_o), 64'd0);
`endif
      expq.delete();
      @(negedge clk);
      @(negedge clk);
      check("midrst_held_valid_o", 64'(bus.valid_o), 64'd0);
      rst = 1'b0;
      out_cyc.delete();
      step(1'b1, 2, 7, 1'b1, a);
      check("postrst_accept", 64'(a), 64'd1);
      drain("postrst_drain");
      check("postrst_out_count", 64'(out_cyc.size()), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, want finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_pipelined_stream.md
# alu_pipelined_stream

Parametrised, back-pressurable successor to the two-stage pipelined ALU. Accepts one operation per cycle over a valid/ready handshake and computes Result and Z/N/C/OF flags. Carries them through a configurable number of register stages, stalling without loss when the consumer deasserts ready. Sits between an operand-issue stage and a writeback/consumer stage that may stall.

## Interface
- WIDTH, 32: operand/result width, ≥ 8.
- STAGES, 2: total register stages (latency), ≥ 2.
- TAG_W, 4: sideband tag width; used only with ALU_PIPE_TAG_EN.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  operation present.
- ready_o  out  1  block can accept; transfer when valid_i && ready_o.
- A_i  in  WIDTH  operand A.
- B_i  in  WIDTH  operand B.
- ALUControl_i  in  4  opcode (encodings in Operation).
- tag_i  in  TAG_W  sideband tag (only with ALU_PIPE_TAG_EN).
- valid_o  out  1  result present.
- ready_i  in  1  consumer accepts; transfer when valid_o && ready_i.
- Result_o  out  WIDTH  result.
- Z_o, N_o, C_o, OF_o  out  1 each  zero, negative, carry, signed overflow.
- tag_o  out  TAG_W  tag aligned with Result_o (only with ALU_PIPE_TAG_EN).

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, result 1/0), 0110 SLL, 0111 SRL, 1000 SRA. All others give Result 0 with all flags 0.
- Shifts use B_i[$clog2(WIDTH)-1:0] only.
- ADD: C = carry out of bit WIDTH-1; OF = signed overflow.
- SUB: computed as A + ~B + 1. C = carry out, so C=1 means A ≥ B unsigned. OF = signed overflow.
- Logic, SLT and shift ops: C=0, OF=0.
- Z = (Result == 0) and N = Result[WIDTH-1] for every defined opcode.
- Stage 1 registers the operands, opcode and tag. The combinational ALU sits between stage 1 and stage 2. Stages 2..STAGES register result, flags and tag. Stage STAGES drives the outputs.
- Each stage has a valid bit. ready[k] = !valid[k] || ready[k+1], where ready[STAGES+1] = ready_i and ready_o = ready[1] && !rst_i.
- A stage loads only when ready[k] is high. Data registers load only when upstream valid is high. Bubbles collapse.
- Ordering is strictly FIFO; no reordering, drop or duplication.

## Timing
- Reset values: valid_o=0, Result_o=0, Z_o=N_o=C_o=OF_o=0, tag_o=0. All stage valids and data registers are 0.
- ready_o is 0 while rst_i is high.
- Reset mid-stream clears all in-flight operations asynchronously. Outputs go to reset values immediately.
- Latency: with ready_i held high, an op accepted at edge n appears on valid_o after edge n+STAGES-1, i.e. it is visible during the STAGES-th cycle after acceptance.
- Throughput: 1 op/cycle while ready_i=1.
- While valid_o && !ready_i, Result_o, flags and tag_o stay stable.
- The pipeline absorbs up to STAGES ops while stalled. ready_o falls combinationally once all stages are full and ready_i=0.
- If ready_i rises in the same cycle as valid_i, the input is accepted and the output is consumed in that cycle; there is no lost slot.
- ready_o depends combinationally on ready_i. This path is accepted by design.

## Configuration
- ALU_PIPE_TAG_EN defined: tag_i/tag_o ports exist. The tag travels with its operation through every stage and resets to 0.
- ALU_PIPE_TAG_EN undefined: no tag ports and no tag registers. TAG_W is ignored.

## Structure
- Package alu_pipelined_pkg holds:
  - alu_op_e enum with the opcode encodings above;
  - default WIDTH/STAGES constants;
  - packed struct alu_res_t {Result, Z, N, C, OF}.
- Sub-module alu_core: a purely combinational ALU (A, B, op -> alu_res_t), instantiated once after stage 1.
- Stages 2..STAGES are a generate loop over an alu_res_t array plus a valid vector.

## Test plan
- WIDTH=32, STAGES=3, ADD 0x7FFFFFFF+0x00000001 -> Result 0x80000000, N=1, OF=1, C=0, Z=0; valid_o asserts after edge n+2 for acceptance at edge n.
- SUB 5-5 -> Result 0, Z=1, C=1, OF=0. SUB 3-5 -> 0xFFFFFFFE, N=1, C=0.
- SRA 0x80000000 by B=0x21 (shift 1) -> 0xC0000000. SLT 0xFFFFFFFF,1 -> 1. Opcode 1111 -> Result 0, all flags 0.
- 8 back-to-back ops with ready_i=1 -> 8 results on 8 consecutive cycles, in order.
- Stream with ready_i=0 for 6 cycles -> exactly 3 ops held, ready_o low, output stable. On release, all ops emerge in order with no loss or duplicate.
- rst_i pulsed high mid-stream (plus tag check with ALU_PIPE_TAG_EN, tags 0..7) -> valid_o=0 immediately and ready_o=0 during reset. The first op after release returns a correct result with a matching tag_o.
